// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register-file write port, with a bulk-clear
// sequencer that writes CLR_VALUE to x1..x(2**ADDR_W-1), one register per cycle.
module rf_write_arbiter #(
  parameter int                NUM_REQ   = 3,
  parameter int                XLEN      = 32,
  parameter int                ADDR_W    = 5,
  parameter logic [XLEN-1:0]   CLR_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [XLEN-1:0]           rf_wdata
);

  localparam int                PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_REG = '1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, grant_idx;
  logic              found;
  logic              we_nxt, done_nxt;
  logic [ADDR_W-1:0] rd_nxt;
  logic [XLEN-1:0]   wdata_nxt;

  logic [ADDR_W-1:0] rd_arr   [NUM_REQ];
  logic [XLEN-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd[g*ADDR_W +: ADDR_W];
    assign data_arr[g] = req_data[g*XLEN +: XLEN];
  end

  // First valid requester at or after ptr, wrapping around.
  always_comb begin : arb
    logic [PW-1:0] cand;
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is suppressed while clearing, on a clear request, and under reset.
  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && !clear_start && found)
      req_ready[grant_idx] = 1'b1;
  end

  assign clear_busy = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we_nxt    = 1'b0;
    done_nxt  = 1'b0;
    rd_nxt    = rf_rd;
    wdata_nxt = rf_wdata;
    case (state)
      IDLE: begin
        if (clear_start) begin
          state_nxt = CLEAR;
          we_nxt    = 1'b1;
          rd_nxt    = ADDR_W'(1);
          wdata_nxt = CLR_VALUE;
        end else if (found) begin
          ptr_nxt   = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
          rd_nxt    = rd_arr[grant_idx];
          wdata_nxt = data_arr[grant_idx];
          // Writes to x0 are accepted but never reach the register file.
          we_nxt    = (rd_arr[grant_idx] != '0);
        end
      end
      CLEAR: begin
        wdata_nxt = CLR_VALUE;
        if (rf_rd == LAST_REG) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          we_nxt = 1'b1;
          rd_nxt = rf_rd + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      rf_we      <= we_nxt;
      rf_rd      <= rd_nxt;
      rf_wdata   <= wdata_nxt;
      clear_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus random
// traffic, all compared against a cycle-indexed behavioural model.
module tb_rf_write_arbiter;

  localparam int NR = 3;
  localparam int XW = 32;
  localparam int AW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*AW-1:0] req_rd;
  logic [NR*XW-1:0] req_data;
  logic [NR-1:0]  req_ready;
  logic           clear_start, clear_busy, clear_done;
  logic           rf_we;
  logic [AW-1:0]  rf_rd;
  logic [XW-1:0]  rf_wdata;

  logic [AW-1:0]  t_rd   [NR];
  logic [XW-1:0]  t_data [NR];

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_rd[g*AW +: AW]   = t_rd[g];
    assign req_data[g*XW +: XW] = t_data[g];
  end

  rf_write_arbiter #(.NUM_REQ(NR), .XLEN(XW), .ADDR_W(AW), .CLR_VALUE('0)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: clears are tracked by their start cycle, writes by a one-deep pipe.
  int            cyc = 0;
  int            m_ptr = 0;
  int            clr_s = -1000;
  bit            pend_we = 1'b0;
  logic [AW-1:0] pend_rd = '0;
  logic [XW-1:0] pend_data = '0;
  int            last_pick = -1;

  logic [NR-1:0] obs_ready;
  logic          obs_we, obs_busy, obs_done;
  logic [AW-1:0] obs_rd;
  logic [XW-1:0] obs_data;

  function automatic int rr_pick(logic [NR-1:0] v, int p);
    logic [NR-1:0] t;
    for (int k = 0; k < NR; k++) begin
      t = v >> ((p + k) % NR);
      if (t[0]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // One clock: check outputs mid-cycle, then advance the model on the edge.
  task automatic cycle();
    int            d, pick;
    bit            busy, exp_we, exp_done;
    logic [AW-1:0] exp_rd;
    logic [XW-1:0] exp_data;
    logic [NR-1:0] exp_ready;
    @(negedge clk);
    d         = cyc - clr_s;
    busy      = (d >= 1 && d <= 31);
    exp_done  = (d == 32);
    pick      = (!reset && !busy && !clear_start) ? rr_pick(req_valid, m_ptr) : -1;
    exp_ready = (pick >= 0) ? (NR'(1) << pick) : '0;
    exp_we    = busy || pend_we;
    exp_rd    = busy ? AW'(d) : pend_rd;
    exp_data  = busy ? '0 : pend_data;
    obs_ready = req_ready; obs_we = rf_we; obs_busy = clear_busy;
    obs_done  = clear_done; obs_rd = rf_rd; obs_data = rf_wdata;

    vectors++;
    if (obs_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL cyc%0d req_ready got %b exp %b", cyc, obs_ready, exp_ready);
    end
    vectors++;
    if (obs_busy !== busy || obs_done !== exp_done) begin
      miscompares++;
      $display("FAIL cyc%0d clear busy/done got %b/%b exp %b/%b", cyc, obs_busy, obs_done, busy, exp_done);
    end
    vectors++;
    if (obs_we !== exp_we) begin
      miscompares++;
      $display("FAIL cyc%0d rf_we got %b exp %b", cyc, obs_we, exp_we);
    end
    if (exp_we) begin
      vectors++;
      if (obs_rd !== exp_rd || obs_data !== exp_data) begin
        miscompares++;
        $display("FAIL cyc%0d rf write got x%0d=%h exp x%0d=%h", cyc, obs_rd, obs_data, exp_rd, exp_data);
      end
    end

    @(posedge clk);
    last_pick = pick;
    if (reset) begin
      m_ptr = 0; clr_s = -1000; pend_we = 1'b0;
    end else begin
      pend_we = 1'b0;
      if (!busy && clear_start) clr_s = cyc;
      else if (pick >= 0) begin
        m_ptr     = (pick + 1) % NR;
        pend_rd   = t_rd[pick];
        pend_data = t_data[pick];
        pend_we   = (t_rd[pick] != '0);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; req_valid = '0; clear_start = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; clear_start = 1'b0;
    for (int i = 0; i < NR; i++) begin t_rd[i] = '0; t_data[i] = '0; end
    cycle(); cycle();
    vectors++;
    if (obs_rd !== '0 || obs_data !== '0 || obs_we !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got we=%b rd=%0d data=%h busy=%b done=%b exp all zero",
               obs_we, obs_rd, obs_data, obs_busy, obs_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    reset_dut();
    t_rd[0] = 5; t_data[0] = 32'hDEAD_BEEF; req_valid = 3'b001;
    cycle();
    vectors++;
    if (obs_ready !== 3'b001) begin
      miscompares++; $display("FAIL single_ready got %b exp 001", obs_ready);
    end
    req_valid = '0;
    cycle();
    vectors++;
    if (obs_we !== 1'b1 || obs_rd !== 5 || obs_data !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_write got we=%b x%0d=%h exp we=1 x5=deadbeef", obs_we, obs_rd, obs_data);
    end
    for (int i = 0; i < NR; i++) t_rd[i] = AW'(20 + i);
    req_valid = 3'b111;
    cycle();
    vectors++;
    if (obs_ready !== 3'b010) begin
      miscompares++; $display("FAIL single_ptr got %b exp 010", obs_ready);
    end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp;
    reset_dut();
    for (int i = 0; i < NR; i++) begin t_rd[i] = AW'(10 + i); t_data[i] = $urandom; end
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      cycle();
      exp = NR'(1) << (k % NR);
      vectors++;
      if (obs_ready !== exp) begin
        miscompares++; $display("FAIL rr_order%0d got %b exp %b", k, obs_ready, exp);
      end
      if (k > 0) begin
        vectors++;
        if (obs_we !== 1'b1) begin
          miscompares++; $display("FAIL rr_we%0d got %b exp 1", k, obs_we);
        end
      end
    end
    req_valid = '0;
    cycle();
    vectors++;
    if (obs_we !== 1'b1) begin
      miscompares++; $display("FAIL rr_last_we got %b exp 1", obs_we);
    end
    cycle();
    vectors++;
    if (obs_we !== 1'b0) begin
      miscompares++; $display("FAIL rr_idle_we got %b exp 0", obs_we);
    end
  endtask

  task automatic test_x0_drop();
    reset_dut();
    t_rd[1] = '0; t_data[1] = 32'hBAD0_0000; req_valid = 3'b010;
    cycle();
    vectors++;
    if (obs_ready !== 3'b010) begin
      miscompares++; $display("FAIL x0_ready got %b exp 010", obs_ready);
    end
    req_valid = '0;
    cycle();
    vectors++;
    if (obs_we !== 1'b0) begin
      miscompares++; $display("FAIL x0_we got %b exp 0", obs_we);
    end
    for (int i = 0; i < NR; i++) t_rd[i] = AW'(1 + i);
    req_valid = 3'b111;
    cycle();
    vectors++;
    if (obs_ready !== 3'b100) begin
      miscompares++; $display("FAIL x0_ptr got %b exp 100", obs_ready);
    end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_clear_collision();
    int writes;
    reset_dut();
    t_rd[1] = 7; t_data[1] = 32'h1234_5678; req_valid = 3'b010; clear_start = 1'b1;
    cycle();
    vectors++;
    if (obs_ready !== '0) begin
      miscompares++; $display("FAIL coll_ready got %b exp 000", obs_ready);
    end
    clear_start = 1'b0;
    writes = 0;
    for (int k = 1; k <= 31; k++) begin
      cycle();
      if (obs_we === 1'b1 && obs_rd === AW'(k) && obs_data === '0) writes++;
    end
    vectors++;
    if (writes !== 31) begin
      miscompares++; $display("FAIL coll_writes got %0d exp 31", writes);
    end
    cycle();
    vectors++;
    if (obs_done !== 1'b1 || obs_ready !== 3'b010) begin
      miscompares++; $display("FAIL coll_resume got done=%b ready=%b exp done=1 ready=010", obs_done, obs_ready);
    end
    req_valid = '0;
    cycle();
    vectors++;
    if (obs_done !== 1'b0 || obs_we !== 1'b1 || obs_rd !== 7 || obs_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL coll_after got done=%b we=%b x%0d=%h exp done=0 we=1 x7=12345678", obs_done, obs_we, obs_rd, obs_data);
    end
  endtask

  task automatic test_reset_mid_clear();
    int writes, dones;
    reset_dut();
    t_rd[1] = 3; req_valid = 3'b010;
    cycle();
    req_valid = '0; clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int k = 1; k <= 9; k++) cycle();
    reset = 1'b1;
    cycle();
    vectors++;
    if (obs_we !== 1'b1 || obs_rd !== 10) begin
      miscompares++; $display("FAIL rmc_x10 got we=%b rd=%0d exp we=1 rd=10", obs_we, obs_rd);
    end
    reset = 1'b0;
    cycle();
    vectors++;
    if (obs_we !== 1'b0 || obs_busy !== 1'b0 || obs_done !== 1'b0) begin
      miscompares++; $display("FAIL rmc_abort got we=%b busy=%b done=%b exp 0/0/0", obs_we, obs_busy, obs_done);
    end
    writes = 0; dones = 0;
    for (int k = 0; k < 35; k++) begin
      cycle();
      if (obs_we === 1'b1) writes++;
      if (obs_done === 1'b1) dones++;
    end
    vectors++;
    if (writes !== 0 || dones !== 0) begin
      miscompares++; $display("FAIL rmc_quiet got writes=%0d dones=%0d exp 0/0", writes, dones);
    end
    for (int i = 0; i < NR; i++) t_rd[i] = AW'(4 + i);
    req_valid = 3'b111;
    cycle();
    vectors++;
    if (obs_ready !== 3'b001) begin
      miscompares++; $display("FAIL rmc_ptr got %b exp 001", obs_ready);
    end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_clear_while_busy();
    int writes, dones;
    reset_dut();
    clear_start = 1'b1;
    cycle();
    writes = 0; dones = 0;
    for (int k = 1; k <= 40; k++) begin
      clear_start = (k == 5);
      cycle();
      if (obs_we === 1'b1) writes++;
      if (obs_done === 1'b1) dones++;
    end
    clear_start = 1'b0;
    vectors++;
    if (writes !== 31 || dones !== 1) begin
      miscompares++; $display("FAIL busy_restart got writes=%0d dones=%0d exp 31/1", writes, dones);
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid[i] = 1'b1;
            t_rd[i]      = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            t_data[i]    = $urandom;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      clear_start = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 149) == 0);
      cycle();
      if (last_pick >= 0) req_valid[last_pick] = 1'b0;
    end
    reset = 1'b0; clear_start = 1'b0; req_valid = '0;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_x0_drop();
    test_clear_collision();
    test_reset_mid_clear();
    test_clear_while_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
